channel_err_inj: RTL and testbench

//  Configurable corrupting channel between the convolutional encoder and the Viterbi decoder. It

---
 rtl/channel_err_inj.sv | 255 +++++++++++++++++++++++++
 tb/tb_channel_err_inj.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_err_inj.sv
// channel_err_inj
//   Corrupting channel placed between the convolutional encoder and the Viterbi
//   decoder. Each accepted encoder symbol is XORed with a mask and registered
//   (1-cycle latency, no backpressure). Four modes are selectable at start_i:
//   OFF, PERIODIC (one error per window), BURST (run of burst_len errors per
//   window, truncated at the window edge) and RANDOM (lfsr[7:0] < thresh_i).
//   Error positions come from a 16-bit Galois LFSR. The LFSR is reloaded with
//   LFSR_SEED on every start_i, so runs with the same configuration repeat exactly.
//   Counters, the window index and the LFSR only move on valid_i cycles.
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   start_i                sample config, clear counters, begin a run (ARM)
//   mode_i                 0 OFF, 1 PERIODIC, 2 BURST, 3 RANDOM
//   win_log_i              window length L = 2**win_log_i, clamped to 1..WIN_W
//   burst_len_i            BURST run length (0 behaves as 1)
//   thresh_i               RANDOM threshold
//   err_pat_i              XOR pattern applied to corrupted symbols
//   valid_i, sym_i         input symbol stream
//   valid_o, sym_o         registered stream, sym_i ^ mask
//   err_mask_o             mask applied to the symbol on sym_o (0 when idle)
//   sym_cnt_o              valid symbols since start (saturating)
//   err_cnt_o              symbols with a nonzero mask (saturating)
//   bit_err_cnt_o          total flipped bits (saturating)
//   busy_o                 run in progress (ARM/WAIT/INJ)
//   done_o                 MAX_SYMS symbols reached; later symbols pass clean
module channel_err_inj #(
    parameter int unsigned SYM_W     = 2,
    parameter int unsigned WIN_W     = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_SYMS  = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [2:0]       win_log_i,
    input  logic [WIN_W-1:0] burst_len_i,
    input  logic [7:0]       thresh_i,
    input  logic [SYM_W-1:0] err_pat_i,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] sym_o,
    output logic [SYM_W-1:0] err_mask_o,
    output logic [CNT_W-1:0] sym_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] bit_err_cnt_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_INJ, S_DONE} state_t;
    typedef enum logic [1:0] {M_OFF, M_PER, M_BURST, M_RAND} mode_t;

    function automatic logic [2:0] clamp_wlog(input logic [2:0] v);
        if (v == 3'd0)
            return 3'd1;
        else if (32'(v) > WIN_W)
            return 3'(WIN_W);
        else
            return v;
    endfunction

    // Galois form of x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v[0])
            return {1'b0, v[15:1]} ^ 16'hB400;
        else
            return {1'b0, v[15:1]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    state_t           r_state;
    mode_t            r_mode;
    logic [2:0]       r_wlog;
    logic [WIN_W-1:0] r_blen;
    logic [7:0]       r_thr;
    logic [SYM_W-1:0] r_pat;
    logic [WIN_W-1:0] r_idx;
    logic [WIN_W-1:0] r_off;
    logic [WIN_W-1:0] r_rem;
    logic [15:0]      r_lfsr;
    logic [CNT_W-1:0] r_scnt;
    logic [CNT_W-1:0] r_ecnt;
    logic [CNT_W-1:0] r_bcnt;
    logic             r_valid;
    logic [SYM_W-1:0] r_sym;
    logic [SYM_W-1:0] r_mask;

    // Effective (current-cycle) values: start_i restarts the run on this very
    // symbol, so it behaves as index 0 of the new run with the new config.
    state_t           w_st;
    mode_t            w_mode;
    logic [2:0]       w_wlog;
    logic [WIN_W-1:0] w_blen;
    logic [7:0]       w_thr;
    logic [SYM_W-1:0] w_pat;
    logic [WIN_W-1:0] w_idx;
    logic [WIN_W-1:0] w_off;
    logic [WIN_W-1:0] w_rem;
    logic [15:0]      w_lfsr;
    logic [CNT_W-1:0] w_scnt;
    logic [CNT_W-1:0] w_ecnt;
    logic [CNT_W-1:0] w_bcnt;

    logic [WIN_W-1:0] w_lmask;
    logic [WIN_W-1:0] w_len;
    logic [WIN_W-1:0] w_arm_off;
    logic             w_active;
    logic             w_win_end;
    logic             w_pos_hit;
    logic             w_hit;
    logic [SYM_W-1:0] w_mask;

    state_t           w_st_nxt;
    logic [WIN_W-1:0] w_idx_nxt;
    logic [WIN_W-1:0] w_off_nxt;
    logic [WIN_W-1:0] w_rem_nxt;
    logic [15:0]      w_lfsr_nxt;
    logic [CNT_W-1:0] w_scnt_nxt;
    logic [CNT_W-1:0] w_ecnt_nxt;
    logic [CNT_W-1:0] w_bcnt_nxt;

    always_comb begin
        w_st   = start_i ? S_ARM : r_state;
        w_mode = start_i ? mode_t'(mode_i) : r_mode;
        w_wlog = start_i ? clamp_wlog(win_log_i) : r_wlog;
        w_blen = start_i ? burst_len_i : r_blen;
        w_thr  = start_i ? thresh_i : r_thr;
        w_pat  = start_i ? err_pat_i : r_pat;
        w_idx  = start_i ? '0 : r_idx;
        w_off  = start_i ? '0 : r_off;
        w_rem  = start_i ? '0 : r_rem;
        w_lfsr = start_i ? LFSR_SEED : r_lfsr;
        w_scnt = start_i ? '0 : r_scnt;
        w_ecnt = start_i ? '0 : r_ecnt;
        w_bcnt = start_i ? '0 : r_bcnt;

        w_lmask   = WIN_W'((32'd1 << w_wlog) - 32'd1);
        w_len     = (w_blen == '0) ? WIN_W'(1) : w_blen;
        w_arm_off = w_lfsr[WIN_W-1:0] & w_lmask;
        w_active  = (w_st == S_ARM) || (w_st == S_WAIT) || (w_st == S_INJ);
        w_win_end = (w_idx == w_lmask);

        w_pos_hit  = 1'b0;
        w_hit      = 1'b0;
        w_st_nxt   = w_st;
        w_idx_nxt  = w_idx;
        w_off_nxt  = w_off;
        w_rem_nxt  = w_rem;
        w_lfsr_nxt = w_lfsr;

        if (valid_i && w_active) begin
            w_lfsr_nxt = lfsr_step(w_lfsr);
            w_idx_nxt  = w_win_end ? '0 : w_idx + WIN_W'(1);
            case (w_st)
                S_ARM: begin
                    // First symbol of a window: its offset is drawn and it may itself be hit
                    w_off_nxt = w_arm_off;
                    w_pos_hit = (w_arm_off == '0);
                    w_st_nxt  = S_WAIT;
                end
                S_WAIT: w_pos_hit = (w_idx == w_off);
                S_INJ: begin
                    w_pos_hit = 1'b1;
                    w_rem_nxt = w_rem - WIN_W'(1);
                    if (w_rem == WIN_W'(1))
                        w_st_nxt = S_WAIT;
                end
                default: ;
            endcase
            if (w_pos_hit && (w_st != S_INJ) && (w_mode == M_BURST) && (w_len > WIN_W'(1))) begin
                w_st_nxt  = S_INJ;
                w_rem_nxt = w_len - WIN_W'(1);
            end
            case (w_mode)
                M_PER, M_BURST: w_hit = w_pos_hit;
                M_RAND:         w_hit = (w_lfsr[7:0] < w_thr);
                default:        w_hit = 1'b0;
            endcase
            // Window edge truncates any burst and re-arms for the next offset
            if (w_win_end)
                w_st_nxt = S_ARM;
            if (w_scnt == CNT_W'(MAX_SYMS - 1))
                w_st_nxt = S_DONE;
        end

        w_mask = w_hit ? w_pat : '0;

        w_scnt_nxt = w_scnt;
        w_ecnt_nxt = w_ecnt;
        w_bcnt_nxt = w_bcnt;
        if (valid_i && (w_st != S_IDLE)) begin
            w_scnt_nxt = sat_add(w_scnt, CNT_W'(1));
            w_ecnt_nxt = sat_add(w_ecnt, CNT_W'(w_mask != '0));
            w_bcnt_nxt = sat_add(w_bcnt, CNT_W'($countones(w_mask)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_mode  <= M_OFF;
            r_wlog  <= '0;
            r_blen  <= '0;
            r_thr   <= '0;
            r_pat   <= '0;
            r_idx   <= '0;
            r_off   <= '0;
            r_rem   <= '0;
            r_lfsr  <= LFSR_SEED;
            r_scnt  <= '0;
            r_ecnt  <= '0;
            r_bcnt  <= '0;
            r_valid <= 1'b0;
            r_sym   <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_st_nxt;
            r_mode  <= w_mode;
            r_wlog  <= w_wlog;
            r_blen  <= w_blen;
            r_thr   <= w_thr;
            r_pat   <= w_pat;
            r_idx   <= w_idx_nxt;
            r_off   <= w_off_nxt;
            r_rem   <= w_rem_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_scnt  <= w_scnt_nxt;
            r_ecnt  <= w_ecnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_valid <= valid_i;
            r_mask  <= valid_i ? w_mask : '0;
            if (valid_i)
                r_sym <= sym_i ^ w_mask;
        end
    end

    assign valid_o       = r_valid;
    assign sym_o         = r_sym;
    assign err_mask_o    = r_mask;
    assign sym_cnt_o     = r_scnt;
    assign err_cnt_o     = r_ecnt;
    assign bit_err_cnt_o = r_bcnt;
    assign busy_o        = (r_state == S_ARM) || (r_state == S_WAIT) || (r_state == S_INJ);
    assign done_o        = (r_state == S_DONE);

endmodule

// File: tb/tb_channel_err_inj.sv
// Testbench for channel_err_inj: stimulus pushes expected outputs / counter
// snapshots into queues; a negedge monitor pops and compares.
module tb_channel_err_inj;

    localparam int MAXS = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic [1:0] mode_i = '0;
    logic [2:0] win_log_i = '0;
    logic [3:0] burst_len_i = '0;
    logic [7:0] thresh_i = '0;
    logic [1:0] err_pat_i = '0;
    logic       valid_i = 1'b0;
    logic [1:0] sym_i = '0;
    logic       valid_o;
    logic [1:0] sym_o;
    logic [1:0] err_mask_o;
    logic [15:0] sym_cnt_o;
    logic [15:0] err_cnt_o;
    logic [15:0] bit_err_cnt_o;
    logic       busy_o;
    logic       done_o;

    channel_err_inj #(.SYM_W(2), .WIN_W(4), .CNT_W(16), .MAX_SYMS(256), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .win_log_i(win_log_i),
        .burst_len_i(burst_len_i), .thresh_i(thresh_i), .err_pat_i(err_pat_i),
        .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o),
        .err_mask_o(err_mask_o), .sym_cnt_o(sym_cnt_o), .err_cnt_o(err_cnt_o),
        .bit_err_cnt_o(bit_err_cnt_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    kind;     // 0 counters, 1 all-zero reset check, 2 drain check
        string name;
        int    e_sym, e_err, e_bit;
        bit    e_busy, e_done;
    } creq_t;

    logic [3:0] q[$];      // {expected sym_o, expected err_mask_o}
    creq_t      cq[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // reference model state
    logic [15:0] lf [0:255];
    bit          started = 0;
    int          k = 0;
    int          m_mode = 0, m_L = 2, m_len = 1, m_thr = 0;
    logic [1:0]  m_pat = '0;
    int          e_sym = 0, e_err = 0, e_bit = 0;

    function automatic logic [1:0] exp_mask(int kk);
        int wi, off;
        bit hit;
        hit = 1'b0;
        if (!started || kk >= MAXS) return 2'b00;
        wi  = kk % m_L;
        off = int'(lf[kk - wi]) & (m_L - 1);
        case (m_mode)
            1: hit = (wi == off);
            2: hit = (wi >= off) && (wi < off + m_len);
            3: hit = (int'(lf[kk][7:0]) < m_thr);
            default: hit = 1'b0;
        endcase
        return hit ? m_pat : 2'b00;
    endfunction

    task automatic push_sym(input logic [1:0] s);
        logic [1:0] m;
        m = exp_mask(k);
        q.push_back({s ^ m, m});
        if (started) begin
            e_sym = (e_sym < 65535) ? e_sym + 1 : e_sym;
            e_err = e_err + ((m != 2'b00) ? 1 : 0);
            e_bit = e_bit + int'(m[0]) + int'(m[1]);
            k++;
        end
    endtask

    task automatic sym(input bit v, input logic [1:0] s);
        start_i     = 1'b0;
        valid_i     = v;
        sym_i       = s;
        mode_i      = 2'($urandom);    // must be ignored outside start_i
        win_log_i   = 3'($urandom);
        burst_len_i = 4'($urandom);
        thresh_i    = 8'($urandom);
        err_pat_i   = 2'($urandom);
        if (v) push_sym(s);
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int md, input int wl, input int bl, input int th,
                            input logic [1:0] pat, input bit v, input logic [1:0] s);
        int wlc;
        start_i     = 1'b1;
        mode_i      = 2'(md);
        win_log_i   = 3'(wl);
        burst_len_i = 4'(bl);
        thresh_i    = 8'(th);
        err_pat_i   = pat;
        valid_i     = v;
        sym_i       = s;
        wlc     = (wl == 0) ? 1 : ((wl > 4) ? 4 : wl);
        started = 1'b1;
        k = 0; e_sym = 0; e_err = 0; e_bit = 0;
        m_mode = md; m_L = 1 << wlc; m_len = (bl == 0) ? 1 : bl; m_thr = th; m_pat = pat;
        if (v) push_sym(s);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic check_counts(input string nm);
        creq_t c;
        c.kind = 0; c.name = nm; c.e_sym = e_sym; c.e_err = e_err; c.e_bit = e_bit;
        c.e_busy = started && (k < MAXS);
        c.e_done = started && (k >= MAXS);
        cq.push_back(c);
    endtask

    task automatic check_hand(input string nm, input int s, input int e, input int b,
                              input bit bz, input bit dn);
        creq_t c;
        c.kind = 0; c.name = nm; c.e_sym = s; c.e_err = e; c.e_bit = b;
        c.e_busy = bz; c.e_done = dn;
        cq.push_back(c);
    endtask

    task automatic push_kind(input int kd, input string nm);
        creq_t c;
        c.kind = kd; c.name = nm; c.e_sym = 0; c.e_err = 0; c.e_bit = 0;
        c.e_busy = 1'b0; c.e_done = 1'b0;
        cq.push_back(c);
    endtask

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // monitor: the only process that steps n_cmp / n_bad
    always @(negedge clk) begin
        creq_t      c;
        logic [3:0] e;
        if (rst) begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid_o", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sym_o", int'(sym_o), int'(e[3:2]));
                    chk("err_mask_o", int'(err_mask_o), int'(e[1:0]));
                end
            end else begin
                chk("idle_err_mask_o", int'(err_mask_o), 0);
            end
        end
        while (cq.size() != 0) begin
            c = cq.pop_front();
            case (c.kind)
                0: begin
                    chk({c.name, ".sym_cnt"}, int'(sym_cnt_o), c.e_sym);
                    chk({c.name, ".err_cnt"}, int'(err_cnt_o), c.e_err);
                    chk({c.name, ".bit_err_cnt"}, int'(bit_err_cnt_o), c.e_bit);
                    chk({c.name, ".busy"}, int'(busy_o), int'(c.e_busy));
                    chk({c.name, ".done"}, int'(done_o), int'(c.e_done));
                end
                1: begin
                    chk({c.name, ".valid_o"}, int'(valid_o), 0);
                    chk({c.name, ".sym_o"}, int'(sym_o), 0);
                    chk({c.name, ".err_mask_o"}, int'(err_mask_o), 0);
                    chk({c.name, ".sym_cnt"}, int'(sym_cnt_o), 0);
                    chk({c.name, ".err_cnt"}, int'(err_cnt_o), 0);
                    chk({c.name, ".bit_err_cnt"}, int'(bit_err_cnt_o), 0);
                    chk({c.name, ".busy"}, int'(busy_o), 0);
                    chk({c.name, ".done"}, int'(done_o), 0);
                end
                default: chk({c.name, ".pending"}, q.size(), 0);
            endcase
        end
    end

    initial begin
        logic [15:0] v;
        lf[0] = 16'hACE1;
        for (int i = 1; i < 256; i++) begin
            v = lf[i-1];
            lf[i] = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        end

        push_kind(1, "reset_state");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // T1: IDLE pass-through, nothing counted
        for (int i = 0; i < 10; i++) sym(1'b1, 2'($urandom));
        check_hand("t1_idle", 0, 0, 0, 1'b0, 1'b0);

        // T2: PERIODIC, L=8, pattern 01: one error per window -> 32 errors
        do_start(1, 3, 0, 0, 2'b01, 1'b1, 2'($urandom));
        for (int i = 1; i < 256; i++) sym(1'b1, 2'($urandom));
        check_hand("t2_done", 256, 32, 32, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) sym(1'b1, 2'($urandom));
        check_counts("t2_after_done");

        // T3: BURST, L=8, len=3, pattern 11 (bits = 2*errors)
        do_start(2, 3, 3, 0, 2'b11, 1'b1, 2'($urandom));
        for (int i = 1; i < 256; i++) sym(1'b1, 2'($urandom));
        check_counts("t3_burst");
        // burst_len=0 behaves as 1
        do_start(2, 3, 0, 0, 2'b10, 1'b1, 2'($urandom));
        for (int i = 1; i < 40; i++) sym(1'b1, 2'($urandom));
        check_hand("t3_len0", 40, 5, 5, 1'b1, 1'b0);

        // T4: RANDOM thresholds, repeated run with the same seed
        do_start(3, 3, 0, 0, 2'b11, 1'b1, 2'($urandom));
        for (int i = 1; i < 60; i++) sym(1'b1, 2'($urandom));
        check_hand("t4_thr0", 60, 0, 0, 1'b1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            do_start(3, 2, 0, 255, 2'b01, 1'b1, 2'($urandom));
            for (int i = 1; i < 60; i++) sym(1'b1, 2'($urandom));
            check_counts("t4_thr255");
        end

        // window clamp: win_log 7 -> L=16, win_log 0 -> L=2
        do_start(1, 7, 0, 0, 2'b10, 1'b1, 2'($urandom));
        for (int i = 1; i < 256; i++) sym(1'b1, 2'($urandom));
        check_hand("clamp_hi", 256, 16, 16, 1'b0, 1'b1);
        do_start(1, 0, 0, 0, 2'b11, 1'b1, 2'($urandom));
        for (int i = 1; i < 64; i++) sym(1'b1, 2'($urandom));
        check_hand("clamp_lo", 64, 32, 64, 1'b1, 1'b0);

        // err_pat 0: FSM steps but nothing is counted
        do_start(1, 2, 0, 0, 2'b00, 1'b1, 2'($urandom));
        for (int i = 1; i < 30; i++) sym(1'b1, 2'($urandom));
        check_hand("pat_zero", 30, 0, 0, 1'b1, 1'b0);

        // T5: PERIODIC with bubbles, same per-index masks as T2
        do_start(1, 3, 0, 0, 2'b01, 1'b0, 2'b00);
        for (int i = 0; i < 2000 && k < 256; i++)
            sym($urandom_range(0, 3) != 0, 2'($urandom));
        check_hand("t5_bubbles", 256, 32, 32, 1'b0, 1'b1);

        // T6: async reset in the middle of a burst (window 0 offset is 1 -> idx 1..3)
        do_start(2, 3, 3, 0, 2'b11, 1'b1, 2'($urandom));
        sym(1'b1, 2'($urandom));
        sym(1'b1, 2'($urandom));
        valid_i = 1'b0;
        #2 rst = 1'b0;
        q.delete();
        started = 1'b0; k = 0; e_sym = 0; e_err = 0; e_bit = 0;
        push_kind(1, "t6_async_reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 5; i++) sym(1'b1, 2'($urandom));
        check_hand("t6_idle", 0, 0, 0, 1'b0, 1'b0);
        // restart mid-run with a new window; index 0 is the start-cycle symbol
        do_start(1, 3, 0, 0, 2'b01, 1'b1, 2'($urandom));
        for (int i = 1; i < 20; i++) sym(1'b1, 2'($urandom));
        check_counts("t6_run1");
        do_start(1, 2, 0, 0, 2'b10, 1'b1, 2'($urandom));
        for (int i = 1; i < 16; i++) sym(1'b1, 2'($urandom));
        check_hand("t6_restart", 16, 4, 4, 1'b1, 1'b0);

        sym(1'b0, 2'b00);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        push_kind(2, "drain");
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
